// File: rtl/ahb_lsu_master.sv
// AHB-Lite load/store master: one SINGLE transfer per core request, with wait
// states, two-cycle ERROR handling and sign/zero-extended load data.
module ahb_lsu_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_RESP} state_t;

  state_t            state, state_nxt;
  logic              req, accept, illegal, set_err;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [DATA_W-1:0] lane, load_val, store_val;

  assign req    = memread | memwrite;
  assign accept = (state == S_IDLE) && req;
  assign HBURST = 3'b000;
  assign stall  = accept || (state == S_ADDR) || (state == S_DATA) || (state == S_ERR);

  // Reserved encodings, misaligned halves/words and unsigned stores never reach the bus.
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b001, 3'b101:         illegal = addr[0];
      3'b010:                 illegal = (addr[1:0] != 2'b00);
      default:                illegal = 1'b0;
    endcase
    if (memwrite && funct3[2]) illegal = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = illegal ? S_RESP : S_ADDR;
          set_err   = illegal;
        end
      end
      S_ADDR: begin
        if (HREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        case ({HREADY, HRESP})
          2'b10:   state_nxt = S_RESP;
          2'b01:   state_nxt = S_ERR;
          2'b11: begin
            state_nxt = S_RESP;
            set_err   = 1'b1;
          end
          default: state_nxt = S_DATA;
        endcase
      end
      S_ERR: begin
        if (HREADY) begin
          state_nxt = S_RESP;
          set_err   = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lane = HRDATA >> {addr_lo_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   load_val = {{(DATA_W-8){~f3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{(DATA_W-16){~f3_q[2] & lane[15]}}, lane[15:0]};
      default: load_val = HRDATA;
    endcase
  end

  // Narrow stores are replicated across all lanes so the slave can pick any.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   store_val = {4{wdata_q[7:0]}};
      2'b01:   store_val = {2{wdata_q[15:0]}};
      default: store_val = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HADDR     <= '0;
      HTRANS    <= 2'b00;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HWDATA    <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      write_q   <= 1'b0;
    end else begin
      done   <= (state_nxt == S_RESP);
      err    <= set_err;
      HTRANS <= (state_nxt == S_ADDR) ? 2'b10 : 2'b00;
      if (accept) begin
        f3_q      <= funct3;
        addr_lo_q <= addr[1:0];
        wdata_q   <= wdata;
        write_q   <= memwrite;
        if (!illegal) begin
          HADDR  <= addr;
          HWRITE <= memwrite;
          HSIZE  <= {1'b0, funct3[1:0]};
        end
      end
      if (state == S_ADDR && HREADY)
        HWDATA <= store_val;
      if (state_nxt == S_RESP && (state == S_DATA || state == S_ERR))
        HWDATA <= '0;
      if (state == S_DATA && HREADY && !HRESP && !write_q)
        rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Directed bench for ahb_lsu_master: transaction-level timeline model checked every cycle.
module tb_ahb_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  ahb_lsu_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle
  logic        exp_vld = 1'b0;
  logic [1:0]  exp_htrans;
  logic        exp_stall, exp_done, exp_err;
  logic [31:0] exp_rdata;
  logic        exp_addr_chk, exp_hwdata_chk;
  logic [31:0] exp_haddr, exp_hwdata;
  logic        exp_hwrite;
  logic [2:0]  exp_hsize;
  logic [31:0] cap_hwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    if (f3[1:0] == 2'b01 && a[0]) return 1'b0;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] hr);
    logic [7:0] b [4];
    int i;
    for (int k = 0; k < 4; k++) b[k] = hr[8*k +: 8];
    i = int'(a[1:0]);
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b[i]} : {{24{b[i][7]}}, b[i]};
      2'b01:   return f3[2] ? {16'h0, b[i+1], b[i]} : {{16{b[i+1][7]}}, b[i+1], b[i]};
      default: return hr;
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("htrans", 32'(HTRANS), 32'(exp_htrans));
      chk("stall",  32'(stall),  32'(exp_stall));
      chk("done",   32'(done),   32'(exp_done));
      chk("err",    32'(err),    32'(exp_err));
      chk("rdata",  rdata,       exp_rdata);
      chk("hburst", 32'(HBURST), 32'd0);
      if (exp_addr_chk) begin
        chk("haddr",  HADDR,       exp_haddr);
        chk("hwrite", 32'(HWRITE), 32'(exp_hwrite));
        chk("hsize",  32'(HSIZE),  32'(exp_hsize));
      end
      if (exp_hwdata_chk) begin
        chk("hwdata", HWDATA, exp_hwdata);
        cap_hwdata = HWDATA;
      end
    end
  end

  // em: 0 OKAY, 1 two-cycle ERROR, 2 HREADY=1 with HRESP=1
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] hr,
                         input int aw, input int dw, input int em, output int lat);
    logic legal;
    int   cyc;
    legal = is_legal(wr, f3, a);
    cyc   = 0;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    exp_htrans = 2'b00; exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr_chk = 1'b0; exp_hwdata_chk = 1'b0;
    step(); cyc++;
    if (legal) begin
      exp_addr_chk = 1'b1; exp_htrans = 2'b10;
      exp_haddr = a; exp_hwrite = wr; exp_hsize = {1'b0, f3[1:0]};
      for (int i = 0; i <= aw; i++) begin
        HREADY = (i == aw);
        step(); cyc++;
      end
      exp_addr_chk = 1'b0; exp_htrans = 2'b00;
      exp_hwdata_chk = wr; exp_hwdata = store_lanes(f3, wd);
      for (int i = 0; i < dw; i++) begin
        HREADY = 1'b0; HRESP = 1'b0;
        step(); cyc++;
      end
      HRDATA = hr;
      case (em)
        0: begin HREADY = 1'b1; HRESP = 1'b0; step(); cyc++; end
        1: begin
          HREADY = 1'b0; HRESP = 1'b1; step(); cyc++;
          HREADY = 1'b1; HRESP = 1'b1; step(); cyc++;
        end
        default: begin HREADY = 1'b1; HRESP = 1'b1; step(); cyc++; end
      endcase
      exp_hwdata_chk = 1'b0;
    end
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    exp_done = 1'b1; exp_err = !legal || (em != 0); exp_stall = 1'b0;
    if (legal && !wr && em == 0) exp_rdata = load_ext(f3, a, hr);
    lat = cyc;
    step();
    memread = 1'b0; memwrite = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
    step();
  endtask

  int lat;

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    exp_htrans = 2'b00; exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_rdata = 32'h0; exp_addr_chk = 1'b1; exp_haddr = 32'h0; exp_hwrite = 1'b0;
    exp_hsize = 3'b000; exp_hwdata_chk = 1'b1; exp_hwdata = 32'h0; cap_hwdata = 32'h0;
    #1 exp_vld = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_addr_chk = 1'b0; exp_hwdata_chk = 1'b0;
    step();

    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, lat);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_rdata", rdata, 32'hDEADBEEF);

    run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, lat);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    run_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, lat);
    chk("lbu_rdata", rdata, 32'h00000080);
    run_txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0, 0, 0, lat);
    chk("lh_rdata", rdata, 32'hFFFF80FF);
    run_txn(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1, 0, 0, lat);
    chk("lhu_rdata", rdata, 32'h0000F00D);
    chk("lhu_latency", 32'(lat), 32'd4);

    run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 2, 0, lat);
    chk("sh_latency", 32'(lat), 32'd5);
    chk("sh_hwdata", cap_hwdata, 32'hABCDABCD);
    run_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h00000055, 32'h0, 1, 0, 0, lat);
    chk("sb_hwdata", cap_hwdata, 32'h55555555);

    run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hBAD0BAD0, 0, 0, 1, lat);
    chk("err_latency", 32'(lat), 32'd4);
    chk("err_rdata_kept", rdata, 32'h0000F00D);
    run_txn(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'hBAD0BAD0, 0, 1, 2, lat);
    chk("viol_rdata_kept", rdata, 32'h0000F00D);

    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0, lat);
    chk("illegal_latency", 32'(lat), 32'd1);
    run_txn(1'b0, 1'b1, 3'b100, 32'h104, 32'h11, 32'h0, 0, 0, 0, lat);
    run_txn(1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 32'h0, 0, 0, 0, lat);

    run_txn(1'b1, 1'b1, 3'b010, 32'h500, 32'hCAFEF00D, 32'h0, 0, 0, 0, lat);
    chk("both_hwdata", cap_hwdata, 32'hCAFEF00D);
    run_txn(1'b1, 1'b0, 3'b010, 32'h50C, 32'h0, 32'h0BADCAFE, 2, 1, 0, lat);
    chk("wait_latency", 32'(lat), 32'd6);

    // Reset lands in the middle of an ADDR wait state.
    memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h400;
    HREADY = 1'b1; HRESP = 1'b0;
    exp_stall = 1'b1; exp_htrans = 2'b00;
    step();
    HREADY = 1'b0;
    exp_addr_chk = 1'b1; exp_htrans = 2'b10; exp_haddr = 32'h400;
    exp_hwrite = 1'b0; exp_hsize = 3'b010;
    #2;
    chk("pre_reset_htrans", 32'(HTRANS), 32'd2);
    reset = 1'b1; memread = 1'b0;
    exp_htrans = 2'b00; exp_stall = 1'b0; exp_haddr = 32'h0; exp_hsize = 3'b000;
    exp_hwdata_chk = 1'b1; exp_hwdata = 32'h0; exp_rdata = 32'h0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    step(); step();
    reset = 1'b0;
    exp_addr_chk = 1'b0; exp_hwdata_chk = 1'b0;
    step();
    step();

    run_txn(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h13579BDF, 0, 0, 0, lat);
    chk("post_reset_latency", 32'(lat), 32'd3);
    chk("post_reset_rdata", rdata, 32'h13579BDF);

    exp_vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lsu_master.md
# ahb_lsu_master

Load/store bus master that consumes the registered `memread`/`memwrite` controls from the core's main decoder and turns each request into a single AHB-Lite transfer. It runs one transfer per request and handles AHB wait states and two-cycle ERROR responses. Loads are returned as sign- or zero-extended register values, and the core is stalled until each access completes. It sits between the core's execute/memory stage and the AHB-Lite interconnect.

## Interface
Parameters:
- `ADDR_W`, default 32: address width (HADDR, addr).
- `DATA_W`, default 32: data width. The design assumes 32, giving 4 byte lanes.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `memread`  in  1  load request. Held by the core until `done`.
- `memwrite`  in  1  store request. Held by the core until `done`.
- `funct3`  in  3  access type. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_W  byte address (ALU result).
- `wdata`  in  DATA_W  store data (rs2), LSB-justified.
- `rdata`  out  DATA_W  extended load result. Valid while `done`=1.
- `stall`  out  1  freeze the core pipeline.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse, coincident with `done`.
- `HADDR`  out  ADDR_W; `HTRANS`  out  2; `HWRITE`  out  1; `HSIZE`  out  3; `HBURST`  out  3 (always 000 SINGLE); `HWDATA`  out  DATA_W.
- `HRDATA`  in  DATA_W; `HREADY`  in  1; `HRESP`  in  1.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - ADDR: address phase, HTRANS=NONSEQ.
  - DATA: data phase, HTRANS=IDLE.
  - ERR: second cycle of the ERROR response.
  - RESP: one cycle, `done`=1. No request is accepted in this state.
- IDLE handling of `req` = `memread | memwrite`:
  - If both inputs are high, `memwrite` wins.
  - `funct3`, `addr`, `wdata` and direction are latched.
  - Illegal access goes IDLE→RESP with `err`=1 and issues no bus transfer. Illegal means:
    - funct3 ∈ {011, 110, 111};
    - a store with funct3[2]=1;
    - H/HU with addr[0]=1;
    - W with addr[1:0]≠00.
  - A legal access goes to ADDR with HADDR=addr, HWRITE=dir, HSIZE={0,funct3[1:0]}, HTRANS=10.
- ADDR: holds all address-phase outputs until HREADY=1 is sampled, then goes to DATA with HTRANS=00.
  - HWDATA is driven from DATA entry until leaving DATA/ERR.
  - SB drives {4{wdata[7:0]}}, SH drives {2{wdata[15:0]}}, SW drives wdata.
- DATA:
  - HREADY=1, HRESP=0: go to RESP.
    - A load captures the lane of HRDATA selected by addr[1:0] into `rdata`.
    - It is sign-extended if funct3[2]=0, else zero-extended.
  - HREADY=0, HRESP=0: wait in DATA.
  - HREADY=0, HRESP=1: go to ERR.
  - HREADY=1, HRESP=1 (protocol violation): go to RESP with `err`=1.
- ERR: wait for HREADY=1, then go to RESP with `err`=1. `rdata` is not updated.
- RESP: `done`=1, then return to IDLE. `rdata` holds its value until the next load completes.
- `stall` (combinational):
  - 1 when `req`=1 in IDLE.
  - 1 in ADDR, DATA and ERR.
  - 0 in RESP.
  - 0 in IDLE with no request.
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HBURST=000, HWDATA=0, `rdata`=0, `done`=0, `err`=0, state=IDLE.
- Reset mid-transfer: all outputs return to their reset values asynchronously and the pending transfer is abandoned. No `done` is pulsed.

## Timing
- All AHB outputs, `rdata`, `done` and `err` are registered. `stall` is the only combinational output.
- Zero-wait-state access: request sampled at edge 0, NONSEQ driven in cycle 1, data phase in cycle 2, `done` in cycle 3. Latency is 3 cycles.
- Each HREADY=0 cycle in ADDR or DATA adds 1 cycle.
- ERROR response: `done` and `err` assert 1 cycle after HREADY=1 is sampled in ERR.
- Illegal access: `done` and `err` assert 1 cycle after the request.
- Back-to-back requests: the next request is accepted no earlier than the cycle after RESP, giving a minimum period of 4 cycles per access.
- HADDR, HWRITE and HSIZE are stable throughout ADDR, including wait cycles. HTRANS is never BUSY or SEQ.

## Test plan
- Zero-wait LW from 0x100 with HRDATA=0xDEADBEEF → NONSEQ in cycle 1, `done` in cycle 3, `rdata`=0xDEADBEEF, `stall`=1 for cycles 0–2.
- LB from 0x103 with HRDATA=0x80FF_0000 → HSIZE=000, `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080.
- SH of wdata=0x1234ABCD to 0x202 with 2 HREADY=0 cycles in DATA → HWDATA=0xABCDABCD held, HWRITE=1, `done` in cycle 5.
- Two-cycle ERROR response on LW from 0x300 → ERR entered, `done` and `err` pulse together, `rdata` is unchanged from its prior value.
- LW from 0x102 → no NONSEQ ever driven, `done`=`err`=1 one cycle later. Both `memread` and `memwrite` high → a write transfer is issued.
- Reset asserted during an ADDR wait state → HTRANS=00 and all outputs 0 immediately, no `done`. A fresh LW after reset completes normally.
